// File: rtl/processor_multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the shared-memory MIPS datapath.
// The master side is the controller; the slave side is the datapath/memory that consumes the controls.
interface processor_multicycle_controller_if;
    logic [5:0] ctl_op;
    logic       mem_ready;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_retired;
    logic       halted;

    modport master (
        input  ctl_op, mem_ready,
        output iord, mem_read, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               instr_retired, halted
    );

    modport slave (
        output ctl_op, mem_ready,
        input  iord, mem_read, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               instr_retired, halted
    );
endinterface

// File: rtl/processor_multicycle_controller.sv
// Moore sequencer for a multicycle MIPS datapath sharing one memory port for fetch and data.
// Outputs decode from the state register; only FETCH/MEMWR qualify strobes with mem_ready.
module processor_multicycle_controller (
    input  logic                                  clk,
    input  logic                                  rst_n,
    processor_multicycle_controller_if.master     bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MEMADR = 4'd3;
    localparam logic [3:0] ST_MEMRD  = 4'd4;
    localparam logic [3:0] ST_MEMWB  = 4'd5;
    localparam logic [3:0] ST_MEMWR  = 4'd6;
    localparam logic [3:0] ST_REX    = 4'd7;
    localparam logic [3:0] ST_RWB    = 4'd8;
    localparam logic [3:0] ST_BEQEX  = 4'd9;
    localparam logic [3:0] ST_AEX    = 4'd10;
    localparam logic [3:0] ST_AWB    = 4'd11;
    localparam logic [3:0] ST_JEX    = 4'd12;
    localparam logic [3:0] ST_HALT   = 4'd13;

    logic [3:0] state_r;
    logic [3:0] state_next_s;

    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       branch_s;
    logic [1:0] pc_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       instr_retired_s;
    logic       halted_s;

    // State register; asynchronous reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing; unknown encodings fall into HALT so they are flagged.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RST:    state_next_s = ST_FETCH;
            ST_FETCH:  state_next_s = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.ctl_op)
                    OP_LW,
                    OP_SW:    state_next_s = ST_MEMADR;
                    OP_RTYPE: state_next_s = ST_REX;
                    OP_BEQ:   state_next_s = ST_BEQEX;
                    OP_ADDI:  state_next_s = ST_AEX;
                    OP_J:     state_next_s = ST_JEX;
                    default:  state_next_s = ST_HALT;
                endcase
            end
            ST_MEMADR: state_next_s = (bus.ctl_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_next_s = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_next_s = ST_FETCH;
            ST_MEMWR:  state_next_s = bus.mem_ready ? ST_FETCH : ST_MEMWR;
            ST_REX:    state_next_s = ST_RWB;
            ST_RWB:    state_next_s = ST_FETCH;
            ST_BEQEX:  state_next_s = ST_FETCH;
            ST_AEX:    state_next_s = ST_AWB;
            ST_AWB:    state_next_s = ST_FETCH;
            ST_JEX:    state_next_s = ST_FETCH;
            ST_HALT:   state_next_s = ST_HALT;
            default:   state_next_s = ST_HALT;
        endcase
    end

    // Control decode: everything idles at 0 and each state raises only its own controls.
    always_comb begin
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        branch_s        = 1'b0;
        pc_src_s        = 2'b00;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        reg_dst_s       = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_write_s     = 1'b0;
        instr_retired_s = 1'b0;
        halted_s        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
            end
            ST_DECODE: begin
                alu_src_b_s = 2'b11;
            end
            ST_MEMADR, ST_AEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            ST_MEMRD: begin
                iord_s     = 1'b1;
                mem_read_s = 1'b1;
            end
            ST_MEMWB: begin
                mem_to_reg_s    = 1'b1;
                reg_write_s     = 1'b1;
                instr_retired_s = 1'b1;
            end
            ST_MEMWR: begin
                iord_s          = 1'b1;
                mem_write_s     = 1'b1;
                instr_retired_s = bus.mem_ready;
            end
            ST_REX: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            ST_RWB: begin
                reg_dst_s       = 1'b1;
                reg_write_s     = 1'b1;
                instr_retired_s = 1'b1;
            end
            ST_BEQEX: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_src_s        = 2'b01;
                branch_s        = 1'b1;
                instr_retired_s = 1'b1;
            end
            ST_AWB: begin
                reg_write_s     = 1'b1;
                instr_retired_s = 1'b1;
            end
            ST_JEX: begin
                pc_src_s        = 2'b10;
                pc_write_s      = 1'b1;
                instr_retired_s = 1'b1;
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    assign bus.iord          = iord_s;
    assign bus.mem_read      = mem_read_s;
    assign bus.mem_write     = mem_write_s;
    assign bus.ir_write      = ir_write_s;
    assign bus.pc_write      = pc_write_s;
    assign bus.branch        = branch_s;
    assign bus.pc_src        = pc_src_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_write     = reg_write_s;
    assign bus.instr_retired = instr_retired_s;
    assign bus.halted        = halted_s;
endmodule

// File: tb/tb_processor_multicycle_controller.sv
// Bench for the multicycle controller: per-instruction expected control streams built from
// the instruction class and stall plan, compared cycle by cycle against the DUT.
module tb_processor_multicycle_controller;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_retired;
        logic       halted;
    } outs_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    outs_t obs_q[$];
    outs_t exp_q[$];

    processor_multicycle_controller_if bus();

    processor_multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o.iord = bus.iord;           o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
        o.ir_write = bus.ir_write;   o.pc_write = bus.pc_write;   o.branch = bus.branch;
        o.pc_src = bus.pc_src;       o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;
        o.alu_op = bus.alu_op;       o.reg_dst = bus.reg_dst;     o.mem_to_reg = bus.mem_to_reg;
        o.reg_write = bus.reg_write; o.instr_retired = bus.instr_retired; o.halted = bus.halted;
        return o;
    endfunction

    function automatic int base_latency(input logic [5:0] op);
        if (op == OP_BEQ || op == OP_J) return 3;
        if (op == OP_LW) return 5;
        return 4;
    endfunction

    // One clock: apply mem_ready, record observed and expected controls mid-cycle, advance.
    task automatic drive(input logic mr, input outs_t e);
        bus.mem_ready = mr;
        #3;
        obs_q.push_back(sample());
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reference: expected control stream of one instruction, starting in FETCH.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        outs_t e;
        obs_q.delete();
        exp_q.delete();
        bus.ctl_op = op;
        for (int i = 0; i < fstall; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            drive(1'b0, e);
        end
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        drive(1'b1, e);
        e = '0; e.alu_src_b = 2'b11;
        drive(1'($urandom_range(0, 1)), e);
        case (op)
            OP_LW, OP_SW: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                drive(1'($urandom_range(0, 1)), e);
                e = '0; e.iord = 1'b1;
                if (op == OP_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                for (int i = 0; i < mstall; i++) drive(1'b0, e);
                if (op == OP_SW) e.instr_retired = 1'b1;
                drive(1'b1, e);
                if (op == OP_LW) begin
                    e = '0; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_retired = 1'b1;
                    drive(1'($urandom_range(0, 1)), e);
                end
            end
            OP_RTYPE: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                drive(1'($urandom_range(0, 1)), e);
                e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_retired = 1'b1;
                drive(1'($urandom_range(0, 1)), e);
            end
            OP_BEQ: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
                e.branch = 1'b1; e.instr_retired = 1'b1;
                drive(1'($urandom_range(0, 1)), e);
            end
            OP_ADDI: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                drive(1'($urandom_range(0, 1)), e);
                e = '0; e.reg_write = 1'b1; e.instr_retired = 1'b1;
                drive(1'($urandom_range(0, 1)), e);
            end
            OP_J: begin
                e = '0; e.pc_src = 2'b10; e.pc_write = 1'b1; e.instr_retired = 1'b1;
                drive(1'($urandom_range(0, 1)), e);
            end
            default: begin
                e = '0; e.halted = 1'b1;
                for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), e);
            end
        endcase
    endtask

    task automatic test_reset();
        outs_t o;
        rst_n = 1'b0;
        bus.ctl_op = 6'b000000;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        o = sample();
        n_cmp++;
        if (o !== outs_t'(0)) begin
            n_fail++; $display("FAIL reset_rst_state: got %h expected %h", o, outs_t'(0));
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #3;
        o = sample();
        n_cmp++;
        if (o.mem_read !== 1'b1 || o.alu_src_b !== 2'b01 || o.ir_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_to_fetch: got %h", o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        run_instr(OP_RTYPE, 0, 0);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rtype cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 4 || obs_q[3].instr_retired !== 1'b1) begin
            n_fail++; $display("FAIL rtype_latency: got %0d cycles expected 4", obs_q.size());
        end
    endtask

    task automatic test_lw_stall();
        int rd_cycles;
        run_instr(OP_LW, 0, 2);
        rd_cycles = 0;
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL lw_stall cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i].iord === 1'b1 && obs_q[i].mem_read === 1'b1) rd_cycles++;
        end
        n_cmp++;
        if (rd_cycles != 3 || obs_q[6].instr_retired !== 1'b1 || obs_q[6].mem_to_reg !== 1'b1) begin
            n_fail++; $display("FAIL lw_memrd_hold: got %0d read cycles expected 3", rd_cycles);
        end
    endtask

    task automatic test_fetch_stall();
        int irw;
        int pcw;
        run_instr(OP_RTYPE, 3, 0);
        irw = 0;
        pcw = 0;
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL fetch_stall cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            irw += int'(obs_q[i].ir_write);
            pcw += int'(obs_q[i].pc_write);
        end
        n_cmp++;
        if (irw != 1 || pcw != 1 || obs_q[3].ir_write !== 1'b1) begin
            n_fail++; $display("FAIL fetch_stall_pulse: got ir_write %0d pc_write %0d expected 1 1", irw, pcw);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [2];
        ops[0] = OP_BEQ;
        ops[1] = OP_J;
        for (int k = 0; k < 2; k++) begin
            run_instr(ops[k], 0, 0);
            foreach (obs_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL b2b op%0d cyc%0d: got %h expected %h", k, i, obs_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (obs_q.size() != 3 || obs_q[2].instr_retired !== 1'b1) begin
                n_fail++; $display("FAIL b2b_latency op%0d: got %0d expected 3", k, obs_q.size());
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] legal [6];
        logic [5:0] op;
        int fs;
        int ms;
        int ret_at;
        int ret_cnt;
        legal[0] = OP_RTYPE; legal[1] = OP_LW;   legal[2] = OP_SW;
        legal[3] = OP_BEQ;   legal[4] = OP_ADDI; legal[5] = OP_J;
        for (int n = 0; n < 40; n++) begin
            op = legal[$urandom_range(0, 5)];
            fs = $urandom_range(0, 3);
            ms = $urandom_range(0, 3);
            run_instr(op, fs, ms);
            ret_at = -1;
            ret_cnt = 0;
            foreach (obs_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d op%h cyc%0d: got %h expected %h", n, op, i, obs_q[i], exp_q[i]);
                end
                n_cmp++;
                if (obs_q[i].mem_read === 1'b1 && obs_q[i].mem_write === 1'b1) begin
                    n_fail++; $display("FAIL rand%0d rd_wr_overlap cyc%0d", n, i);
                end
                if (obs_q[i].instr_retired === 1'b1) begin
                    ret_cnt++;
                    if (ret_at < 0) ret_at = i + 1;
                end
            end
            if (op != OP_LW && op != OP_SW) ms = 0;
            n_cmp++;
            if (ret_cnt != 1 || ret_at != base_latency(op) + fs + ms) begin
                n_fail++; $display("FAIL rand%0d latency op%h: got %0d (pulses %0d) expected %0d",
                                   n, op, ret_at, ret_cnt, base_latency(op) + fs + ms);
            end
        end
    endtask

    task automatic test_reset_mid_memwr();
        outs_t e;
        outs_t o;
        obs_q.delete();
        exp_q.delete();
        bus.ctl_op = OP_SW;
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        drive(1'b1, e);
        e = '0; e.alu_src_b = 2'b11;
        drive(1'b1, e);
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        drive(1'b1, e);
        e = '0; e.iord = 1'b1; e.mem_write = 1'b1;
        drive(1'b0, e);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL sw_to_memwr cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        bus.mem_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        o = sample();
        n_cmp++;
        if (o !== outs_t'(0)) begin
            n_fail++; $display("FAIL memwr_reset_drop: got %h expected %h", o, outs_t'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #3;
        o = sample();
        n_cmp++;
        if (o !== outs_t'(0)) begin
            n_fail++; $display("FAIL memwr_reset_rst: got %h expected %h", o, outs_t'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_halt();
        outs_t o;
        run_instr(6'b111111, 0, 0);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL halt cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        rst_n = 1'b0;
        #1;
        o = sample();
        n_cmp++;
        if (o.halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_clear: got halted %b expected 0", o.halted);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ctl_op = OP_RTYPE;
        @(posedge clk);
        #1;
        run_instr(OP_RTYPE, 0, 0);
        n_cmp++;
        if (obs_q[3].instr_retired !== 1'b1 || obs_q[3].reg_dst !== 1'b1) begin
            n_fail++; $display("FAIL halt_recover: got %h expected %h", obs_q[3], exp_q[3]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.ctl_op = 6'b000000;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_fetch_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_memwr();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
